// File: rtl/sc_regshifter_flags_if.sv
// sc_regshifter_flags_if: control, ALU-result and BUSC/flag signals of the shifter stage.
interface sc_regshifter_flags_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
);
    logic                                      SC_REGSHIFTER_clear_InLow;
    logic                                      SC_REGSHIFTER_load_InLow;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_shiftselection_In;
    logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_InBUS;
    logic                                      SC_REGSHIFTER_overflow_InLow;
    logic                                      SC_REGSHIFTER_carry_InLow;
    logic                                      SC_REGSHIFTER_negative_InLow;
    logic                                      SC_REGSHIFTER_zero_InLow;
    logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_OutBUS;
    logic                                      SC_REGSHIFTER_overflow_OutLow;
    logic                                      SC_REGSHIFTER_carry_OutLow;
    logic                                      SC_REGSHIFTER_negative_OutLow;
    logic                                      SC_REGSHIFTER_zero_OutLow;

    modport master (
        output SC_REGSHIFTER_clear_InLow, SC_REGSHIFTER_load_InLow, SC_REGSHIFTER_shiftselection_In,
               SC_REGSHIFTER_data_InBUS, SC_REGSHIFTER_overflow_InLow, SC_REGSHIFTER_carry_InLow,
               SC_REGSHIFTER_negative_InLow, SC_REGSHIFTER_zero_InLow,
        input  SC_REGSHIFTER_data_OutBUS, SC_REGSHIFTER_overflow_OutLow, SC_REGSHIFTER_carry_OutLow,
               SC_REGSHIFTER_negative_OutLow, SC_REGSHIFTER_zero_OutLow
    );

    modport slave (
        input  SC_REGSHIFTER_clear_InLow, SC_REGSHIFTER_load_InLow, SC_REGSHIFTER_shiftselection_In,
               SC_REGSHIFTER_data_InBUS, SC_REGSHIFTER_overflow_InLow, SC_REGSHIFTER_carry_InLow,
               SC_REGSHIFTER_negative_InLow, SC_REGSHIFTER_zero_InLow,
        output SC_REGSHIFTER_data_OutBUS, SC_REGSHIFTER_overflow_OutLow, SC_REGSHIFTER_carry_OutLow,
               SC_REGSHIFTER_negative_OutLow, SC_REGSHIFTER_zero_OutLow
    );
endinterface

// File: rtl/sc_regshifter_flags.sv
// sc_regshifter_flags: ALU result register with clear/load/shift and registered active-low flags.
// Define SC_REGSHIFTER_ROTATE_EN to turn the left/right shifts into rotates.
module sc_regshifter_flags #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
    input logic SC_REGSHIFTER_CLOCK_50,
    input logic SC_REGSHIFTER_RESET_InHigh,
    sc_regshifter_flags_if.slave bus
);
    localparam int W = DATAWIDTH_BUS;
    localparam logic [3:0] F_CLEAR = 4'b0001;

    logic [W-1:0] r_q, r_d, shl, shr;
    logic [3:0]   f_q, f_d;
    logic         shr_n;

`ifdef SC_REGSHIFTER_ROTATE_EN
    assign shl   = {r_q[W-2:0], r_q[W-1]};
    assign shr   = {r_q[0], r_q[W-1:1]};
    assign shr_n = r_q[0];
`else
    assign shl   = {r_q[W-2:0], 1'b0};
    assign shr   = {1'b0, r_q[W-1:1]};
    assign shr_n = 1'b0;
`endif

    // flags held as {V,C,N,Z}, active-high internally
    always_comb begin
        r_d = r_q;
        f_d = f_q;
        if (!bus.SC_REGSHIFTER_clear_InLow) begin
            r_d = '0;
            f_d = F_CLEAR;
        end else if (!bus.SC_REGSHIFTER_load_InLow) begin
            r_d = bus.SC_REGSHIFTER_data_InBUS;
            f_d = ~{bus.SC_REGSHIFTER_overflow_InLow, bus.SC_REGSHIFTER_carry_InLow,
                    bus.SC_REGSHIFTER_negative_InLow, bus.SC_REGSHIFTER_zero_InLow};
        end else if (bus.SC_REGSHIFTER_shiftselection_In == DATAWIDTH_REGSHIFTER_SELECTION'(1)) begin
            r_d = shl;
            f_d = {r_q[W-1] ^ r_q[W-2], r_q[W-1], r_q[W-2], shl == '0};
        end else if (bus.SC_REGSHIFTER_shiftselection_In == DATAWIDTH_REGSHIFTER_SELECTION'(2)) begin
            r_d = shr;
            f_d = {1'b0, r_q[0], shr_n, shr == '0};
        end
    end

    always_ff @(posedge SC_REGSHIFTER_CLOCK_50) begin
        if (SC_REGSHIFTER_RESET_InHigh) begin
            r_q <= '0;
            f_q <= F_CLEAR;
        end else begin
            r_q <= r_d;
            f_q <= f_d;
        end
    end

    assign bus.SC_REGSHIFTER_data_OutBUS     = r_q;
    assign bus.SC_REGSHIFTER_overflow_OutLow = ~f_q[3];
    assign bus.SC_REGSHIFTER_carry_OutLow    = ~f_q[2];
    assign bus.SC_REGSHIFTER_negative_OutLow = ~f_q[1];
    assign bus.SC_REGSHIFTER_zero_OutLow     = ~f_q[0];
endmodule
